// File: rtl/spm_scrubber_pkg.sv
// Shared types and constants for the SPM background ECC scrubber.
package spm_scrubber_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PEND    = 3'd1,
      ST_WAIT_RD = 3'd2,
      ST_WB      = 3'd3,
      ST_WAIT_WR = 3'd4,
      ST_ADV     = 3'd5
   } scrub_state_e;

   // Consecutive user-blocked cycles in PEND before the scrub read is forced.
   localparam int unsigned ForceThreshold = 16;
   localparam int unsigned ForceCntWidth  = $clog2(ForceThreshold + 1);

endpackage

// File: rtl/spm_scrubber_chk.sv
// Protocol checks for the scrubber: every SPM response must match an outstanding request.
module spm_scrubber_chk (
   input logic clk_i,
   input logic rst_ni,
   input logic pop_i,
   input logic empty_i
);

   // A response with no tracked request means the SPM broke the one-response-per-request rule.
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_i))
      else $error("spm_scrubber: response received with no outstanding request");

endmodule

// File: rtl/spm_scrubber_tag_fifo.sv
// In-order tag FIFO remembering whether each outstanding SPM request came from the scrubber.
module spm_scrubber_tag_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  logic data_i,
   input  logic pop_i,
   output logic data_o,
   output logic full_o,
   output logic empty_o
);
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Depth-1:0]    mem_q;
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [PtrWidth:0]   cnt_q;
   logic                do_push_s;
   logic                do_pop_s;

   assign full_o    = (cnt_q == (PtrWidth + 1)'(Depth));
   assign empty_o   = (cnt_q == '0);
   assign data_o    = mem_q[rd_ptr_q];
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;

   // Storage, pointers and occupancy; pointers wrap naturally since Depth is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
         end
         if (do_push_s && !do_pop_s) begin
            cnt_q <= cnt_q + (PtrWidth + 1)'(1);
         end else if (!do_push_s && do_pop_s) begin
            cnt_q <= cnt_q - (PtrWidth + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/spm_scrubber.sv
// Background ECC scrubber and user/scrub request arbiter in front of a single-port SPM.
module spm_scrubber
   import spm_scrubber_pkg::*;
#(
   parameter int unsigned NumWords       = 512,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned ByteWidth      = 8,
   parameter int unsigned ScrubInterval  = 1024,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned CntWidth       = 16,
   parameter int unsigned AddrWidth      = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth        = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 usr_valid_i,
   output logic                 usr_ready_o,
   input  logic                 usr_we_i,
   input  logic [AddrWidth-1:0] usr_addr_i,
   input  logic [DataWidth-1:0] usr_wdata_i,
   input  logic [BeWidth-1:0]   usr_be_i,
   output logic                 usr_rvalid_o,
   output logic [DataWidth-1:0] usr_rdata_o,
   output logic [1:0]           usr_rerror_o,
   output logic                 mem_valid_o,
   input  logic                 mem_ready_i,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [BeWidth-1:0]   mem_be_o,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   input  logic [1:0]           mem_rerror_i,
   input  logic                 scrub_en_i,
   output logic                 sweep_done_o,
   output logic [CntWidth-1:0]  corr_cnt_o,
   output logic [CntWidth-1:0]  uncorr_cnt_o,
   output logic [AddrWidth-1:0] uncorr_addr_o,
   input  logic                 cnt_clr_i
);
   localparam int unsigned          IntWidth = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
   localparam logic [IntWidth-1:0]  IntLast  = IntWidth'(ScrubInterval - 1);
   localparam logic [AddrWidth-1:0] PtrLast  = AddrWidth'(NumWords - 1);

   scrub_state_e             state_q;
   logic [AddrWidth-1:0]     ptr_q;
   logic [IntWidth-1:0]      int_cnt_q;
   logic [ForceCntWidth-1:0] blk_cnt_q;
   logic [DataWidth-1:0]     wb_data_q;
   logic [CntWidth-1:0]      corr_cnt_q, corr_cnt_d;
   logic [CntWidth-1:0]      uncorr_cnt_q, uncorr_cnt_d;
   logic [AddrWidth-1:0]     uncorr_addr_q;
   logic                     sweep_done_q;

   logic fifo_full_s, fifo_empty_s, tag_is_scrub_s;
   logic push_s, forced_s, user_grant_s, scrub_req_s;
   logic scrub_rsp_s, user_rsp_s, corr_inc_s, uncorr_inc_s;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (v == '1) ? v : v + CntWidth'(1);
   endfunction

   assign forced_s     = (state_q == ST_PEND) && (blk_cnt_q == ForceCntWidth'(ForceThreshold));
   assign push_s       = mem_valid_o & mem_ready_i;
   assign scrub_rsp_s  = mem_rvalid_i & ~fifo_empty_s & tag_is_scrub_s;
   assign user_rsp_s   = mem_rvalid_i & ~fifo_empty_s & ~tag_is_scrub_s;
   assign corr_inc_s   = (state_q == ST_WB) & push_s;
   assign uncorr_inc_s = (state_q == ST_WAIT_RD) & scrub_rsp_s & mem_rerror_i[1];

   // Port ownership: user may issue only in IDLE/PEND and never once the scrub read is forced.
   always_comb begin
      user_grant_s = ~fifo_full_s & ((state_q == ST_IDLE) | ((state_q == ST_PEND) & ~forced_s));
      scrub_req_s  = 1'b0;
      if (fifo_full_s) begin
         scrub_req_s = 1'b0;
      end else if (state_q == ST_PEND) begin
         scrub_req_s = ~usr_valid_i | forced_s;
      end else if (state_q == ST_WB) begin
         scrub_req_s = 1'b1;
      end else begin
         scrub_req_s = 1'b0;
      end
   end

   // Combinational request mux towards the SPM.
   always_comb begin
      mem_valid_o = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (scrub_req_s) begin
         mem_valid_o = 1'b1;
         mem_we_o    = (state_q == ST_WB);
         mem_addr_o  = ptr_q;
         mem_wdata_o = (state_q == ST_WB) ? wb_data_q : '0;
         mem_be_o    = '1;
      end else begin
         mem_valid_o = usr_valid_i & user_grant_s;
         mem_we_o    = usr_we_i;
         mem_addr_o  = usr_addr_i;
         mem_wdata_o = usr_wdata_i;
         mem_be_o    = usr_be_i;
      end
   end

   assign usr_ready_o   = mem_ready_i & user_grant_s;
   assign usr_rvalid_o  = user_rsp_s;
   assign usr_rdata_o   = user_rsp_s ? mem_rdata_i : '0;
   assign usr_rerror_o  = user_rsp_s ? mem_rerror_i : 2'b00;
   assign sweep_done_o  = sweep_done_q;
   assign corr_cnt_o    = corr_cnt_q;
   assign uncorr_cnt_o  = uncorr_cnt_q;
   assign uncorr_addr_o = uncorr_addr_q;

   // Saturating event counters; a clear wins over a coincident increment.
   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clr_i) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else begin
         corr_cnt_d   = corr_inc_s ? sat_inc(corr_cnt_q) : corr_cnt_q;
         uncorr_cnt_d = uncorr_inc_s ? sat_inc(uncorr_cnt_q) : uncorr_cnt_q;
      end
   end

   // Scrub sequencer with its pointer, interval timer, writeback buffer and status registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         int_cnt_q     <= '0;
         blk_cnt_q     <= '0;
         wb_data_q     <= '0;
         corr_cnt_q    <= '0;
         uncorr_cnt_q  <= '0;
         uncorr_addr_q <= '0;
         sweep_done_q  <= 1'b0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
         sweep_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (scrub_en_i) begin
                  if (int_cnt_q == IntLast) state_q <= ST_PEND;
                  else int_cnt_q <= int_cnt_q + IntWidth'(1);
               end
            end
            ST_PEND: begin
               if (push_s && scrub_req_s) begin
                  blk_cnt_q <= '0;
                  state_q   <= ST_WAIT_RD;
               end else if (!forced_s) begin
                  blk_cnt_q <= usr_valid_i ? blk_cnt_q + ForceCntWidth'(1) : '0;
               end
            end
            ST_WAIT_RD: begin
               if (scrub_rsp_s) begin
                  if (mem_rerror_i[1]) begin
                     uncorr_addr_q <= ptr_q;
                     state_q       <= ST_ADV;
                  end else if (mem_rerror_i[0]) begin
                     wb_data_q <= mem_rdata_i;
                     state_q   <= ST_WB;
                  end else begin
                     state_q <= ST_ADV;
                  end
               end
            end
            ST_WB: begin
               if (push_s) state_q <= ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
               if (scrub_rsp_s) state_q <= ST_ADV;
            end
            ST_ADV: begin
               int_cnt_q <= '0;
               state_q   <= ST_IDLE;
               if (ptr_q == PtrLast) begin
                  ptr_q        <= '0;
                  sweep_done_q <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + AddrWidth'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   spm_scrubber_tag_fifo #(
      .Depth (MaxOutstanding)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .data_i  (scrub_req_s),
      .pop_i   (mem_rvalid_i),
      .data_o  (tag_is_scrub_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   spm_scrubber_chk u_chk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .pop_i   (mem_rvalid_i),
      .empty_i (fifo_empty_s)
   );

endmodule

// File: tb/tb_spm_scrubber.sv
// Directed bench for spm_scrubber with an 8-word, 1-cycle-latency SPM model and error injection.
module tb_spm_scrubber;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        usr_valid_i, usr_ready_o, usr_we_i;
   logic [2:0]  usr_addr_i;
   logic [31:0] usr_wdata_i;
   logic [3:0]  usr_be_i;
   logic        usr_rvalid_o;
   logic [31:0] usr_rdata_o;
   logic [1:0]  usr_rerror_o;
   logic        mem_valid_o, mem_ready_i, mem_we_o;
   logic [2:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [1:0]  mem_rerror_i;
   logic        scrub_en_i, sweep_done_o, cnt_clr_i;
   logic [1:0]  corr_cnt_o, uncorr_cnt_o;
   logic [2:0]  uncorr_addr_o;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] spm [8];
   logic [1:0]  err_inj [8];

   int          rd_cnt = 0, wr_cnt = 0, rv_cnt = 0, sw_cnt = 0;
   logic [2:0]  last_rd_addr = 3'd0, last_wr_addr = 3'd0;
   logic [31:0] last_wr_data = 32'd0;
   logic [3:0]  last_wr_be = 4'd0;

   always #5 clk_i = ~clk_i;

   spm_scrubber #(
      .NumWords(8), .DataWidth(32), .ByteWidth(8), .ScrubInterval(4),
      .MaxOutstanding(4), .CntWidth(2)
   ) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .usr_valid_i(usr_valid_i), .usr_ready_o(usr_ready_o), .usr_we_i(usr_we_i),
      .usr_addr_i(usr_addr_i), .usr_wdata_i(usr_wdata_i), .usr_be_i(usr_be_i),
      .usr_rvalid_o(usr_rvalid_o), .usr_rdata_o(usr_rdata_o), .usr_rerror_o(usr_rerror_o),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rerror_i(mem_rerror_i),
      .scrub_en_i(scrub_en_i), .sweep_done_o(sweep_done_o),
      .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
      .uncorr_addr_o(uncorr_addr_o), .cnt_clr_i(cnt_clr_i)
   );

   // SPM model: one response per accepted request, next cycle; reads report the injected error code.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_rvalid_i <= 1'b0;
         mem_rdata_i  <= 32'd0;
         mem_rerror_i <= 2'b00;
         for (int i = 0; i < 8; i++) spm[i] <= 32'd0;
      end else begin
         mem_rvalid_i <= mem_valid_o & mem_ready_i;
         if (mem_valid_o && mem_ready_i) begin
            if (mem_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be_o[b]) spm[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
               mem_rdata_i  <= 32'd0;
               mem_rerror_i <= 2'b00;
            end else begin
               mem_rdata_i  <= spm[mem_addr_o];
               mem_rerror_i <= err_inj[mem_addr_o];
            end
         end
      end
   end

   // Traffic monitor on the SPM side and on the user response / sweep outputs.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         if (mem_valid_o && mem_ready_i) begin
            if (mem_we_o) begin
               wr_cnt       <= wr_cnt + 1;
               last_wr_addr <= mem_addr_o;
               last_wr_data <= mem_wdata_o;
               last_wr_be   <= mem_be_o;
            end else begin
               rd_cnt       <= rd_cnt + 1;
               last_rd_addr <= mem_addr_o;
            end
         end
         if (usr_rvalid_o) rv_cnt <= rv_cnt + 1;
         if (sweep_done_o) sw_cnt <= sw_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one user request starting at a negedge; returns the response seen one cycle after acceptance.
   task automatic usr_req(input logic we, input logic [2:0] a, input logic [31:0] d,
                          output logic ok, output logic rv, output logic [31:0] rd,
                          output logic [1:0] re);
      ok = 1'b0;
      usr_valid_i = 1'b1; usr_we_i = we; usr_addr_i = a; usr_wdata_i = d; usr_be_i = 4'hF;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (usr_ready_o) begin ok = 1'b1; break; end
         @(negedge clk_i);
      end
      if (ok) @(posedge clk_i);
      #1 usr_valid_i = 1'b0;
      @(negedge clk_i);
      rv = usr_rvalid_o; rd = usr_rdata_o; re = usr_rerror_o;
   endtask

   initial begin
      logic        ok, rv;
      logic [31:0] rd;
      logic [1:0]  re;
      int          rd0, wr0, rv0, sw0, wr1, wr2, hs, lo;

      for (int i = 0; i < 8; i++) err_inj[i] = 2'b00;
      rst_ni = 1'b0; usr_valid_i = 1'b0; usr_we_i = 1'b0; usr_addr_i = 3'd0;
      usr_wdata_i = 32'd0; usr_be_i = 4'h0; mem_ready_i = 1'b1; scrub_en_i = 1'b0; cnt_clr_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_rvalid", 32'(usr_rvalid_o), 32'd0);
      chk("rst_rdata", usr_rdata_o, 32'd0);
      chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
      chk("rst_sweep", 32'(sweep_done_o), 32'd0);
      chk("rst_corr", 32'(corr_cnt_o), 32'd0);
      chk("rst_uncorr", 32'(uncorr_cnt_o), 32'd0);
      chk("rst_uaddr", 32'(uncorr_addr_o), 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Passthrough with scrubbing off.
      rd0 = rd_cnt; wr0 = wr_cnt; rv0 = rv_cnt;
      usr_req(1'b1, 3'd5, 32'hDEADBEEF, ok, rv, rd, re);
      chk("wr5_accept", 32'(ok), 32'd1);
      chk("wr5_rvalid", 32'(rv), 32'd1);
      usr_req(1'b0, 3'd5, 32'd0, ok, rv, rd, re);
      chk("rd5_rvalid", 32'(rv), 32'd1);
      chk("rd5_rdata", rd, 32'hDEADBEEF);
      chk("rd5_rerror", 32'(re), 32'd0);
      usr_req(1'b1, 3'd3, 32'h12345678, ok, rv, rd, re);
      chk("wr3_rvalid", 32'(rv), 32'd1);
      repeat (20) @(negedge clk_i);
      chk("pt_mem_reqs", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd3);
      chk("pt_rvalids", 32'(rv_cnt - rv0), 32'd3);

      // Correctable error at address 3.
      err_inj[3] = 2'b01;
      rd0 = rd_cnt; wr0 = wr_cnt; rv0 = rv_cnt; sw0 = sw_cnt;
      scrub_en_i = 1'b1;
      for (int i = 0; i < 300 && wr_cnt == wr0; i++) @(negedge clk_i);
      chk("wb_seen", 32'(wr_cnt - wr0), 32'd1);
      chk("wb_addr", 32'(last_wr_addr), 32'd3);
      chk("wb_data", last_wr_data, 32'h12345678);
      chk("wb_be", 32'(last_wr_be), 32'hF);
      chk("wb_reads", 32'(rd_cnt - rd0), 32'd4);
      chk("wb_corr", 32'(corr_cnt_o), 32'd1);
      chk("scrub_no_rvalid", 32'(rv_cnt - rv0), 32'd0);
      err_inj[3] = 2'b00;

      // Uncorrectable error at address 7.
      err_inj[7] = 2'b10;
      for (int i = 0; i < 300 && uncorr_cnt_o == 2'd0; i++) @(negedge clk_i);
      chk("unc_cnt", 32'(uncorr_cnt_o), 32'd1);
      chk("unc_addr", 32'(uncorr_addr_o), 32'd7);
      chk("unc_no_wb", 32'(wr_cnt - wr0), 32'd1);
      chk("unc_corr_hold", 32'(corr_cnt_o), 32'd1);
      err_inj[7] = 2'b00;

      // Sweep completion and pointer wrap.
      for (int i = 0; i < 300 && sw_cnt == sw0; i++) @(negedge clk_i);
      chk("sweep1_reads", 32'(rd_cnt - rd0), 32'd8);
      chk("sweep1_last", 32'(last_rd_addr), 32'd7);
      @(negedge clk_i);
      chk("sweep1_pulses", 32'(sw_cnt - sw0), 32'd1);
      chk("sweep1_width", 32'(sweep_done_o), 32'd0);
      for (int i = 0; i < 300 && rd_cnt < rd0 + 9; i++) @(negedge clk_i);
      chk("wrap_addr", 32'(last_rd_addr), 32'd0);
      for (int i = 0; i < 600 && sw_cnt < sw0 + 2; i++) @(negedge clk_i);
      chk("sweep2_reads", 32'(rd_cnt - rd0), 32'd16);
      chk("sweep2_pulses", 32'(sw_cnt - sw0), 32'd2);
      chk("sweep2_no_wb", 32'(wr_cnt - wr0), 32'd1);

      // Counter clear, saturation, and clear-versus-increment.
      cnt_clr_i = 1'b1;
      @(negedge clk_i);
      cnt_clr_i = 1'b0;
      chk("clr_corr", 32'(corr_cnt_o), 32'd0);
      chk("clr_uncorr", 32'(uncorr_cnt_o), 32'd0);
      for (int i = 0; i < 8; i++) err_inj[i] = 2'b01;
      wr1 = wr_cnt;
      for (int i = 0; i < 800 && wr_cnt < wr1 + 5; i++) @(negedge clk_i);
      chk("sat_writes", 32'(wr_cnt - wr1), 32'd5);
      chk("sat_corr", 32'(corr_cnt_o), 32'd3);
      for (int i = 0; i < 200 && !(mem_valid_o && mem_we_o); i++) @(negedge clk_i);
      chk("collide_wb_pending", 32'(mem_valid_o && mem_we_o), 32'd1);
      wr2 = wr_cnt;
      cnt_clr_i = 1'b1;
      @(negedge clk_i);
      cnt_clr_i = 1'b0;
      chk("collide_wb_done", 32'(wr_cnt - wr2), 32'd1);
      chk("collide_corr", 32'(corr_cnt_o), 32'd0);
      for (int i = 0; i < 200 && wr_cnt < wr2 + 2; i++) @(negedge clk_i);
      chk("after_clr_corr", 32'(corr_cnt_o), 32'd1);
      scrub_en_i = 1'b0;
      for (int i = 0; i < 8; i++) err_inj[i] = 2'b00;
      repeat (40) @(negedge clk_i);

      // Forced scrub read under continuous user traffic, from a fresh reset.
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      usr_valid_i = 1'b1; usr_we_i = 1'b0; usr_addr_i = 3'd2; usr_be_i = 4'hF;
      scrub_en_i = 1'b1;
      hs = 0;
      #1;
      while (usr_ready_o && hs < 100) begin
         hs++;
         @(negedge clk_i);
         #1;
      end
      chk("force_user_hs", 32'(hs), 32'd20);
      chk("force_mem_valid", 32'(mem_valid_o), 32'd1);
      chk("force_mem_we", 32'(mem_we_o), 32'd0);
      chk("force_mem_addr", 32'(mem_addr_o), 32'd0);
      lo = 0;
      while (!usr_ready_o && lo < 50) begin
         lo++;
         @(negedge clk_i);
         #1;
      end
      chk("force_stall_cycles", 32'(lo), 32'd3);
      usr_valid_i = 1'b0;
      scrub_en_i = 1'b0;
      repeat (5) @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
